// File: rtl/sha3_pkg.sv
// Definitions shared by the SHA3 stream stages: mode encoding, rate lookup and
// the pad10*1 domain-separation byte constants.
package sha3_pkg;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_mode_e;

  localparam logic [7:0] PAD_FIRST = 8'h06;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  // Rate in 16-bit words: (1600 - 2*digest_bits) / 16.
  function automatic logic [6:0] rate_words(input sha3_mode_e m);
    case (m)
      SHA3_224: return 7'd72;
      SHA3_256: return 7'd68;
      SHA3_384: return 7'd52;
      default:  return 7'd36;
    endcase
  endfunction

endpackage

// File: rtl/sha3_pad_packer_if.sv
// Stream bundle around the pad/packer: message input, block output and mode.
interface sha3_pad_packer_if #(parameter int WIDTH = 16);
  logic [1:0]         mode;
  logic [WIDTH-1:0]   s_tdata;
  logic [WIDTH/8-1:0] s_tkeep;
  logic               s_tlast;
  logic               s_tvalid;
  logic               s_tready;
  logic [WIDTH-1:0]   m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;
  logic               m_tuser;

  modport master (
    output mode, s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
  );

  modport slave (
    input  mode, s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
  );
endinterface

// File: rtl/sha3_pad_packer.sv
// Applies SHA3 pad10*1 to a byte stream and emits rate-sized blocks of 16-bit
// words, flagging each block end (m_tlast) and the final block end (m_tuser).
module sha3_pad_packer
  import sha3_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 7
) (
  input  logic           ACLK,
  input  logic           ARESET,
  sha3_pad_packer_if.slave bus
);

  typedef enum logic {S_DATA, S_PAD} state_e;

  state_e             state;
  logic [CNT_W-1:0]   wcnt;
  sha3_mode_e         mode_q;
  logic               in_msg;
  logic               pend06;
  logic [WIDTH-1:0]   tdata_q;
  logic               tvalid_q, tlast_q, tuser_q;

  sha3_mode_e         eff_mode;
  logic [CNT_W-1:0]   rw_last;
  logic               at_last, load, acc, emit;

  logic [WIDTH-1:0]   nxt_data;
  logic               nxt_tuser, msg_end, to_pad, pend_set;

  // The first word of a message is judged against the incoming mode, since the
  // latch only captures it on that same edge.
  assign eff_mode = in_msg ? mode_q : sha3_mode_e'(bus.mode);
  assign rw_last  = CNT_W'(rate_words(eff_mode)) - CNT_W'(1);
  assign at_last  = (wcnt == rw_last);
  assign load     = !tvalid_q || bus.m_tready;
  assign bus.s_tready = !ARESET && (state == S_DATA) && load;
  assign acc      = bus.s_tvalid && bus.s_tready;
  assign emit     = acc || (state == S_PAD);

  always_comb begin
    nxt_data  = '0;
    nxt_tuser = 1'b0;
    msg_end   = 1'b0;
    to_pad    = 1'b0;
    pend_set  = 1'b0;
    if (state == S_PAD) begin
      nxt_data  = {(at_last ? PAD_LAST : 8'h00), (pend06 ? PAD_FIRST : 8'h00)};
      nxt_tuser = at_last;
      msg_end   = at_last;
    end else if (bus.s_tlast) begin
      case (bus.s_tkeep)
        2'b01: begin
          nxt_data  = {(at_last ? (PAD_LAST | PAD_FIRST) : PAD_FIRST), bus.s_tdata[7:0]};
          nxt_tuser = at_last;
          msg_end   = at_last;
          to_pad    = !at_last;
        end
        2'b00: begin
          nxt_data  = {(at_last ? PAD_LAST : 8'h00), PAD_FIRST};
          nxt_tuser = at_last;
          msg_end   = at_last;
          to_pad    = !at_last;
        end
        default: begin
          // Full last word: the 0x06 byte has to open the padding run instead.
          nxt_data  = bus.s_tdata;
          to_pad    = 1'b1;
          pend_set  = 1'b1;
        end
      endcase
    end else begin
      nxt_data = bus.s_tdata;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= S_DATA;
      wcnt     <= '0;
      mode_q   <= sha3_mode_e'(bus.mode);
      in_msg   <= 1'b0;
      pend06   <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else if (load) begin
      tvalid_q <= emit;
      if (emit) begin
        tdata_q <= nxt_data;
        tlast_q <= at_last;
        tuser_q <= nxt_tuser;
        wcnt    <= at_last ? '0 : wcnt + CNT_W'(1);
        if (acc && !in_msg) mode_q <= sha3_mode_e'(bus.mode);
        in_msg  <= !msg_end;
        if (state == S_PAD) begin
          pend06 <= 1'b0;
          if (at_last) state <= S_DATA;
        end else if (to_pad) begin
          state  <= S_PAD;
          pend06 <= pend_set;
        end
      end
    end
  end

  assign bus.m_tdata  = tdata_q;
  assign bus.m_tvalid = tvalid_q;
  assign bus.m_tlast  = tlast_q;
  assign bus.m_tuser  = tuser_q;

endmodule

// File: tb/tb_sha3_pad_packer.sv
// Randomized bench for sha3_pad_packer: byte-level pad10*1 model feeds a
// scoreboard checked on every output transfer and every stalled cycle.
module tb_sha3_pad_packer;
  import sha3_pkg::*;

  typedef struct packed {
    logic [15:0] d;
    logic        tl;
    logic        tu;
  } word_t;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  sha3_pad_packer_if bus ();

  sha3_pad_packer dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  word_t      exp_q[$];
  word_t      mdl_q[$];
  logic [7:0] msg [0:1023];
  int         n_checks = 0;
  int         n_pass = 0;
  bit         chk_en = 1'b1;
  bit         bp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Rate in words from digest size: capacity is twice the digest.
  function automatic int rw_of(input int md);
    int dig [4] = '{224, 256, 384, 512};
    return (1600 - 2 * dig[md]) / 16;
  endfunction

  function automatic logic [7:0] pad_byte(input int i, input int n, input int total);
    logic [7:0] b;
    b = (i < n) ? msg[i] : ((i == n) ? 8'h06 : 8'h00);
    if (i == total - 1) b = b | 8'h80;
    return b;
  endfunction

  task automatic model(input int n, input int md);
    int rw, r, total;
    word_t w;
    rw = rw_of(md);
    r = 2 * rw;
    total = ((n + 1 + r - 1) / r) * r;
    mdl_q.delete();
    for (int j = 0; j < total / 2; j++) begin
      w.d  = {pad_byte(2 * j + 1, n, total), pad_byte(2 * j, n, total)};
      w.tl = ((j % rw) == rw - 1);
      w.tu = (j == total / 2 - 1);
      mdl_q.push_back(w);
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
  endtask

  // Output side: ready, with optional 3-cycle stalls.
  initial begin
    bus.m_tready = 1'b1;
    forever begin
      @(posedge ACLK); #1;
      if (bp_en && $urandom_range(0, 5) == 0) begin
        bus.m_tready = 1'b0;
        repeat (3) begin @(posedge ACLK); #1; end
        bus.m_tready = 1'b1;
      end
    end
  end

  // Scoreboard compare on the falling edge.
  initial begin
    logic        held;
    logic [18:0] held_v;
    word_t       e;
    held = 1'b0;
    held_v = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET || !chk_en) begin
        held = 1'b0;
      end else begin
        if (held)
          check("stall_stable", 32'({bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.m_tuser}), 32'(held_v));
        if (bus.m_tvalid && bus.m_tready) begin
          if (exp_q.size() == 0) begin
            check("extra_word", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("out_word", 32'({bus.m_tdata, bus.m_tlast, bus.m_tuser}), 32'({e.d, e.tl, e.tu}));
          end
        end
        held = bus.m_tvalid && !bus.m_tready;
        held_v = {bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.m_tuser};
      end
    end
  end

  task automatic send_word(input logic [15:0] d, input logic [1:0] k, input logic l);
    bit acc;
    int wait_n;
    acc = 1'b0;
    wait_n = 0;
    while ($urandom_range(0, 3) == 0) begin
      bus.s_tvalid = 1'b0;
      @(posedge ACLK); #1;
    end
    bus.s_tdata = d;
    bus.s_tkeep = k;
    bus.s_tlast = l;
    bus.s_tvalid = 1'b1;
    while (!acc) begin
      @(negedge ACLK);
      acc = bus.s_tready;
      @(posedge ACLK); #1;
      if (!acc) begin
        wait_n++;
        if (wait_n > 5000) begin
          $display("FAIL accept_timeout: got no s_tready in %0d cycles required acceptance", wait_n);
          $fatal(1, "input acceptance timed out");
        end
      end
    end
    bus.s_tvalid = 1'b0;
  endtask

  task automatic send_msg(input int n, input int md, input bit trail);
    int  nfull;
    bit  odd, last_full, lst;
    model(n, md);
    if (chk_en) foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    bus.mode = 2'(md);
    nfull = n / 2;
    odd = (n % 2) == 1;
    last_full = !odd && !trail && n > 0;
    for (int k = 0; k < nfull; k++) begin
      lst = (k == nfull - 1) && last_full;
      send_word({msg[2 * k + 1], msg[2 * k]}, lst ? 2'b11 : 2'($urandom), lst);
      bus.mode = 2'($urandom);
    end
    if (odd) send_word({8'($urandom), msg[n - 1]}, 2'b01, 1'b1);
    else if (!last_full) send_word(16'($urandom), 2'b00, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(posedge ACLK);
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge ACLK); #1;
  endtask

  task automatic set_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
  endtask

  task automatic pin_models();
    model(0, 1);
    check("pin_empty_len", 32'(mdl_q.size()), 32'd68);
    check("pin_empty_w0", 32'(mdl_q[0]), 32'({16'h0006, 1'b0, 1'b0}));
    check("pin_empty_w66", 32'(mdl_q[66]), 32'({16'h0000, 1'b0, 1'b0}));
    check("pin_empty_w67", 32'(mdl_q[67]), 32'({16'h8000, 1'b1, 1'b1}));
    set_abc();
    model(3, 1);
    check("pin_abc_w0", 32'(mdl_q[0]), 32'({16'h6261, 1'b0, 1'b0}));
    check("pin_abc_w1", 32'(mdl_q[1]), 32'({16'h0663, 1'b0, 1'b0}));
    check("pin_abc_w67", 32'(mdl_q[67]), 32'({16'h8000, 1'b1, 1'b1}));
    model(3, 2);
    check("pin_abc384_len", 32'(mdl_q.size()), 32'd52);
    fill_rand(72);
    model(72, 3);
    check("pin_72_len", 32'(mdl_q.size()), 32'd72);
    check("pin_72_w35_flags", 32'({mdl_q[35].tl, mdl_q[35].tu}), 32'b10);
    check("pin_72_w36", 32'(mdl_q[36]), 32'({16'h0006, 1'b0, 1'b0}));
    check("pin_72_w71", 32'(mdl_q[71]), 32'({16'h8000, 1'b1, 1'b1}));
    fill_rand(143);
    msg[142] = 8'hAB;
    model(143, 0);
    check("pin_143_len", 32'(mdl_q.size()), 32'd72);
    check("pin_143_w71", 32'(mdl_q[71]), 32'({16'h86AB, 1'b1, 1'b1}));
  endtask

  initial begin
    int vcnt;
    bus.mode = 2'd0;
    bus.s_tdata = '0;
    bus.s_tkeep = 2'b11;
    bus.s_tlast = 1'b0;
    bus.s_tvalid = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_s_tready", 32'(bus.s_tready), 32'd0);
    check("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    check("rst_m_tdata", 32'(bus.m_tdata), 32'd0);
    check("rst_m_flags", 32'({bus.m_tlast, bus.m_tuser}), 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    pin_models();

    // Directed messages, no output stalls.
    send_msg(0, 1, 1'b1);
    set_abc(); send_msg(3, 1, 1'b0);
    fill_rand(72); send_msg(72, 3, 1'b0);
    fill_rand(143); msg[142] = 8'hAB; send_msg(143, 0, 1'b0);
    drain();

    // Same shapes under back-pressure.
    bp_en = 1'b1;
    set_abc(); send_msg(3, 1, 1'b0);
    send_msg(0, 1, 1'b1);
    fill_rand(72); send_msg(72, 3, 1'b0);
    drain();

    // Reset in the middle of a mode-2 message.
    bp_en = 1'b0;
    chk_en = 1'b0;
    fill_rand(20);
    bus.mode = 2'd2;
    for (int k = 0; k < 10; k++) send_word({msg[2 * k + 1], msg[2 * k]}, 2'b11, 1'b0);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("midrst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    vcnt = 0;
    repeat (30) begin
      @(negedge ACLK);
      if (bus.m_tvalid) vcnt++;
    end
    check("midrst_no_pad", 32'(vcnt), 32'd0);
    @(posedge ACLK); #1;
    chk_en = 1'b1;
    set_abc(); send_msg(3, 2, 1'b0);
    drain();

    // Randomized traffic.
    bp_en = 1'b1;
    for (int m = 0; m < 40; m++) begin
      int n;
      n = $urandom_range(0, 300);
      fill_rand(n);
      send_msg(n, $urandom_range(0, 3), 1'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
